wrapper_drq_arbiter: RTL

- Shares one DMA controller request/handshake port between the per-channel DMA request lines (drq_ch0..drq_ch4) from the wrapper request control registers.
- Grants one channel at a time, round-robin.
- Holds the grant until the DMA controller signals transfer completion.
- Watchdog: a stuck transfer raises an interrupt and releases the port.

---
 rtl/wrapper_drq_arbiter_pkg.sv | 15 +
 rtl/wrapper_rr_pick.sv | 40 ++++
 rtl/wrapper_drq_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wrapper_drq_arbiter_pkg.sv
// Shared types and default sizing for the DMA request arbiter.
package wrapper_drq_arbiter_pkg;

  localparam int unsigned DEF_NUM_CH         = 5;
  localparam int unsigned DEF_TIMEOUT_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/wrapper_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i.
module wrapper_rr_pick
  import wrapper_drq_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] rr_ptr_i,
  output logic [NUM_CH-1:0]         onehot_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o,
  output logic                      valid_o
);

  localparam int unsigned IDW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] rot;
  logic              found;
  int unsigned       off;
  int unsigned       sum;

  // Rotate the doubled request vector so rr_ptr_i lands at bit 0, priority-encode,
  // then map the offset back to an absolute channel index.
  always_comb begin
    rot   = NUM_CH'({req_i, req_i} >> rr_ptr_i);
    found = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = 32'(rr_ptr_i) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    valid_o  = found;
    idx_o    = found ? IDW'(sum) : '0;
    onehot_o = found ? (NUM_CH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/wrapper_drq_arbiter.sv
// Round-robin arbiter sharing one DMA controller handshake among NUM_CH request lines,
// with a saturating watchdog that flags and releases a stuck transfer.
module wrapper_drq_arbiter
  import wrapper_drq_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned TIMEOUT_W      = DEF_TIMEOUT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         drq_in,
  output logic                      dma_req,
  input  logic                      dma_active,
  input  logic                      dma_done,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_id,
  output logic                      busy,
  output logic                      timeout_irq,
  input  logic                      timeout_clr
);

  localparam int unsigned            IDW       = $clog2(NUM_CH);
  localparam logic [TIMEOUT_W-1:0]   WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0]         LAST_CH   = IDW'(NUM_CH - 1);

  arb_state_t           state_q, state_d;
  logic [NUM_CH-1:0]    grant_q, grant_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 irq_q, irq_d;

  logic [NUM_CH-1:0]    pick_onehot;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_valid;

  logic [TIMEOUT_W-1:0] wdog_inc;
  logic                 wdog_last;
  logic                 go_gap;
  logic                 timeout_set;

  wrapper_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req_i    (drq_in),
    .rr_ptr_i (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state logic: arbitration, handshake tracking, watchdog and interrupt.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    irq_d       = irq_q;
    go_gap      = 1'b0;
    timeout_set = 1'b0;
    wdog_last   = (wdog_q == WDOG_LAST);
    wdog_inc    = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (enable && pick_valid) begin
          state_d    = REQ;
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          rr_ptr_d   = (pick_idx == LAST_CH) ? '0 : pick_idx + 1'b1;
          wdog_d     = '0;
        end
      end
      REQ: begin
        wdog_d = wdog_inc;
        if (dma_active) begin
          state_d = ACTIVE;
        end else if (!drq_in[grant_id_q]) begin
          go_gap = 1'b1;
        end else if (wdog_last) begin
          go_gap      = 1'b1;
          timeout_set = 1'b1;
        end
      end
      ACTIVE: begin
        wdog_d = wdog_inc;
        if (dma_done) begin
          go_gap = 1'b1;
        end else if (wdog_last) begin
          go_gap      = 1'b1;
          timeout_set = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_gap) begin
      state_d    = GAP;
      grant_d    = '0;
      grant_id_d = '0;
    end

    if (timeout_clr) irq_d = 1'b0;
    if (timeout_set) irq_d = 1'b1;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      wdog_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_q     <= wdog_d;
      irq_q      <= irq_d;
    end
  end

  assign dma_req     = (state_q == REQ) || (state_q == ACTIVE);
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign timeout_irq = irq_q;

endmodule
